ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Host-side PS/2 keyboard receiver. Turns raw ps2_clk/ps2_data into the 11-bit
//  toggle-strobe event word ps2_key[10:0] that drives the keyboard matrix/scancode
//  block: a serial frame receiver plus a set-2 prefix decoder (E0/F0/E1).
//  Sits between the board PS/2 pins and the keyboard block.
// PARAMETERS
//  CLK_HZ      28000000  system clock frequency, used for the timeout
//  TIMEOUT_US  1000      max gap between ps2_clk falling edges inside a frame
//  FILTER_LEN  8         consecutive equal samples before filtered ps2_clk changes
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   synchronous, active-low reset
//  ps2_clk_i   in   1   PS/2 clock pin, asynchronous
//  ps2_data_i  in   1   PS/2 data pin, asynchronous
//  ps2_key     out  11  [10] toggles per event, [9] 1=press, [8] extended (E0), [7:0] code
//  rx_byte     out  8   last good received byte
//  rx_stb      out  1   1-cycle pulse when rx_byte is updated
//  rx_err      out  1   1-cycle pulse on framing, parity or timeout error
// BEHAVIOUR
//  Reset: reset_n sampled low on clk forces ps2_key=0, rx_byte=0, rx_stb=0, rx_err=0.
//   Filter, bit counter, timeout counter and decoder all go to idle.
//  Input path
//   - Each pin passes a 2-FF synchroniser.
//   - Filtered clk changes state only after FILTER_LEN equal synchronised samples.
//   - A falling edge of filtered clk samples synchronised data.
//  Frame (bit counter 0..10)
//   - Order: start=0, D0..D7 LSB first, odd parity, stop=1.
//   - Start bit sampled as 1: ignore the edge and stay idle (no error).
//   - Bad parity or stop=0: drop the byte, pulse rx_err, bit counter -> 0, decoder -> IDLE.
//   - Good frame: rx_byte loads and rx_stb pulses on the cycle after the stop-bit edge.
//  Timeout
//   - Counter holds CLK_HZ/1e6*TIMEOUT_US cycles.
//   - Reloads on every falling edge; runs only while bit counter is nonzero.
//   - On expiry: abort the frame, pulse rx_err, bit counter -> 0, decoder -> IDLE.
//  Decoder FSM (advances on rx_stb; ps2_key updates on the cycle after rx_stb)
//   IDLE : E0->EXT; F0->REL; E1->SKIP(cnt=7); AA/FA/EE/FE/00/FF ignored;
//          other b -> emit {~k[10],1,0,b}
//   EXT  : F0->EXTREL; E0 stays EXT; other b -> emit {~k[10],1,1,b}, ->IDLE
//   REL  : b -> emit {~k[10],0,0,b}, ->IDLE (E0 in REL -> EXTREL)
//   EXTREL: b -> emit {~k[10],0,1,b}, ->IDLE
//   SKIP : each byte decrements cnt; at cnt==0 ->IDLE. Pause emits nothing.
//  Event word
//   - Each emit sets ps2_key[9:0] and inverts ps2_key[10] in the same cycle.
//   - ps2_key holds its value between emits. Consumers edge-detect bit 10.
//   - Minimum gap between emits is one PS/2 frame, so no back-pressure is needed.
//  Errors and reset
//   - Any rx_err discards a pending prefix; a lost F0 must never yield a press.
//   - reset_n low mid-frame: the partial frame is discarded. The next start bit
//     begins a fresh frame.
// STRUCTURE
//  - Sub-module ps2_rx_frame: synchroniser, filter, bit counter, parity, timeout.
//    Outputs rx_byte/rx_stb/rx_err.
//  - Top level holds the decoder FSM and the ps2_key register.
//  - Shared package: prefix constants (8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE,
//    8'hFE) and the decoder state enum.
// TESTING
//  - Frame 0x1C (A) -> rx_stb, rx_byte=1C; ps2_key 000 -> 0x61C.
//    Then F0,1C -> ps2_key 0x01C (bit10 toggled back).
//  - E0,75 -> {1,1,1,75}. Then E0,F0,75 -> {0,0,1,75}. Exactly 2 toggles of bit10.
//  - Frame 0x29 with parity forced even -> rx_err pulse, no rx_stb, ps2_key unchanged.
//    A later good 0x29 emits a press.
//  - F0, then a frame stalled after 4 bits for >TIMEOUT_US -> rx_err.
//    Next 0x1A decodes as a press {1,0,1A}, not a release.
//  - Pause: E1,14,77,E1,F0,14,F0,77 -> 8 rx_stb, no ps2_key change.
//    Following 0x5A -> press 5A.
//  - 1-cycle glitch (< FILTER_LEN) on ps2_clk -> no bit sampled.
//    reset_n low mid-frame -> outputs 0, clean decode of the next frame.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 set-2 receiver: prefix/reply codes and decoder states.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PFX_EXT     = 8'hE0;
    localparam logic [7:0] PFX_REL     = 8'hF0;
    localparam logic [7:0] PFX_PAUSE   = 8'hE1;
    localparam logic [7:0] CODE_BAT    = 8'hAA;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;

    typedef logic [2:0] dec_state_t;

    localparam dec_state_t ST_IDLE   = 3'd0;
    localparam dec_state_t ST_EXT    = 3'd1;
    localparam dec_state_t ST_REL    = 3'd2;
    localparam dec_state_t ST_EXTREL = 3'd3;
    localparam dec_state_t ST_SKIP   = 3'd4;

    // Bytes a keyboard sends that are never key codes when seen outside a prefix.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == CODE_BAT) || (b == CODE_ACK) || (b == CODE_ECHO) ||
               (b == CODE_RESEND) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Pin and event-word bundle between the PS/2 pins, the decoder and the keyboard block.
interface ps2_key_decoder_if;

    logic        ps2_clk_i;
    logic        ps2_data_i;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_stb;
    logic        rx_err;

    modport master (
        output ps2_clk_i, ps2_data_i,
        input  ps2_key, rx_byte, rx_stb, rx_err
    );

    modport slave (
        input  ps2_clk_i, ps2_data_i,
        output ps2_key, rx_byte, rx_stb, rx_err
    );

endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 serial frame receiver: pin synchronisers, clock glitch filter, 11-bit framing,
// odd-parity check and inter-edge timeout.
module ps2_rx_frame #(
    parameter int CLK_HZ     = 28000000,
    parameter int TIMEOUT_US = 1000,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte,
    output logic       rx_stb,
    output logic       rx_err
);

    localparam int TMO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             filt_clk_q, filt_clk_d;
    logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_stb_q, rx_stb_d;
    logic             rx_err_q, rx_err_d;
    logic             fall;
    logic             data_s;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
        data_sync_d = {data_sync_q[0], ps2_data_i};
        data_s      = data_sync_q[1];

        // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
        filt_clk_d = filt_clk_q;
        filt_cnt_d = filt_cnt_q;
        fall       = 1'b0;
        if (clk_sync_q[1] == filt_clk_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FLT_LAST) begin
            filt_clk_d = clk_sync_q[1];
            filt_cnt_d = '0;
            fall       = filt_clk_q;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end

        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        rx_byte_d = rx_byte_q;
        rx_stb_d  = 1'b0;
        rx_err_d  = 1'b0;

        if (fall) begin
            tmo_d = TMO_LOAD;
            case (bit_cnt_q)
                4'd0: begin
                    if (!data_s) bit_cnt_d = 4'd1;
                end
                4'd9: begin
                    par_d     = data_s;
                    bit_cnt_d = 4'd10;
                end
                4'd10: begin
                    bit_cnt_d = 4'd0;
                    if (data_s && ((^shift_q) ^ par_q)) begin
                        rx_byte_d = shift_q;
                        rx_stb_d  = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
                default: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            endcase
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == '0) begin
                rx_err_d  = 1'b1;
                bit_cnt_d = 4'd0;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            rx_byte_q   <= 8'h00;
            rx_stb_q    <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_stb_q    <= rx_stb_d;
            rx_err_q    <= rx_err_d;
        end
    end

    // Shift/parity/timeout contents are only meaningful while bit_cnt_q is nonzero.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
        tmo_q   <= tmo_d;
    end

    assign rx_byte = rx_byte_q;
    assign rx_stb  = rx_stb_q;
    assign rx_err  = rx_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard host receiver: frame receiver plus set-2 prefix decoder producing the
// toggle-strobe event word ps2_key.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int CLK_HZ     = 28000000,
    parameter int TIMEOUT_US = 1000,
    parameter int FILTER_LEN = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    ps2_key_decoder_if.slave  bus
);

    logic [7:0]  rx_byte;
    logic        rx_stb;
    logic        rx_err;
    dec_state_t  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [10:0] key_q, key_d;

    ps2_rx_frame #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_i  (bus.ps2_clk_i),
        .ps2_data_i (bus.ps2_data_i),
        .rx_byte    (rx_byte),
        .rx_stb     (rx_stb),
        .rx_err     (rx_err)
    );

    function automatic logic [10:0] make_event(input logic tog, input logic press,
                                               input logic ext, input logic [7:0] b);
        return {tog, press, ext, b};
    endfunction

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        key_d   = key_q;
        // A receive error drops any pending prefix so a lost F0 never turns into a press.
        if (rx_err) begin
            state_d = ST_IDLE;
            skip_d  = 3'd0;
        end else if (rx_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == PFX_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_byte == PFX_REL) begin
                        state_d = ST_REL;
                    end else if (rx_byte == PFX_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_ignored(rx_byte)) begin
                        key_d = make_event(~key_q[10], 1'b1, 1'b0, rx_byte);
                    end
                end
                ST_EXT: begin
                    if (rx_byte == PFX_REL) begin
                        state_d = ST_EXTREL;
                    end else if (rx_byte != PFX_EXT) begin
                        key_d   = make_event(~key_q[10], 1'b1, 1'b1, rx_byte);
                        state_d = ST_IDLE;
                    end
                end
                ST_REL: begin
                    if (rx_byte == PFX_EXT) begin
                        state_d = ST_EXTREL;
                    end else begin
                        key_d   = make_event(~key_q[10], 1'b0, 1'b0, rx_byte);
                        state_d = ST_IDLE;
                    end
                end
                ST_EXTREL: begin
                    key_d   = make_event(~key_q[10], 1'b0, 1'b1, rx_byte);
                    state_d = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            key_q   <= 11'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            key_q   <= key_d;
        end
    end

    assign bus.ps2_key = key_q;
    assign bus.rx_byte = rx_byte;
    assign bus.rx_stb  = rx_stb;
    assign bus.rx_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames on the pins and checks the
// received bytes, error pulses and the event word after each step.
module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .CLK_HZ     (4000000),
        .TIMEOUT_US (50),
        .FILTER_LEN (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;
    int tog_cnt  = 0;
    logic prev10 = 1'b0;
    int s0, e0, t0;

    always @(negedge clk) begin
        if (bus.rx_stb === 1'b1) stb_cnt <= stb_cnt + 1;
        if (bus.rx_err === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.ps2_key[10] !== prev10) tog_cnt <= tog_cnt + 1;
        prev10 <= bus.ps2_key[10];
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data_i = b;
        cyc(HALF);
        bus.ps2_clk_i = 1'b0;
        cyc(HALF);
        bus.ps2_clk_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(bad_par ? (^b) : ~(^b));
        ps2_bit(1'b1);
        bus.ps2_data_i = 1'b1;
        cyc(3 * HALF);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] stall_b;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        bus.ps2_clk_i  = 1'b1;
        bus.ps2_data_i = 1'b1;
        reset_n = 1'b0;
        cyc(5);
        check("reset_key",  32'(bus.ps2_key), 32'h000);
        check("reset_byte", 32'(bus.rx_byte), 32'h00);
        check("reset_stb",  32'(bus.rx_stb),  32'h0);
        check("reset_err",  32'(bus.rx_err),  32'h0);
        reset_n = 1'b1;
        cyc(20);

        s0 = stb_cnt;
        send_frame(8'h1C, 1'b0);
        check("a_stb_count", 32'(stb_cnt - s0), 32'd1);
        check("a_rx_byte",   32'(bus.rx_byte), 32'h1C);
        check("a_press",     32'(bus.ps2_key), 32'h61C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("a_release",   32'(bus.ps2_key), 32'h01C);

        t0 = tog_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("ext_press",   32'(bus.ps2_key), 32'h775);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("ext_release", 32'(bus.ps2_key), 32'h175);
        check("ext_toggles", 32'(tog_cnt - t0), 32'd2);

        s0 = stb_cnt;
        e0 = err_cnt;
        send_frame(8'h29, 1'b1);
        check("par_err",     32'(err_cnt - e0), 32'd1);
        check("par_no_stb",  32'(stb_cnt - s0), 32'd0);
        check("par_key",     32'(bus.ps2_key), 32'h175);
        send_frame(8'h29, 1'b0);
        check("par_recover", 32'(bus.ps2_key), 32'h629);

        send_frame(8'hF0, 1'b0);
        e0 = err_cnt;
        stall_b = 8'h1A;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(stall_b[i]);
        bus.ps2_data_i = 1'b1;
        cyc(400);
        check("tmo_err",     32'(err_cnt - e0), 32'd1);
        send_frame(8'h1A, 1'b0);
        check("tmo_press",   32'(bus.ps2_key), 32'h21A);

        s0 = stb_cnt;
        for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0);
        check("pause_stb",   32'(stb_cnt - s0), 32'd8);
        check("pause_key",   32'(bus.ps2_key), 32'h21A);
        send_frame(8'h5A, 1'b0);
        check("pause_after", 32'(bus.ps2_key), 32'h65A);

        s0 = stb_cnt;
        e0 = err_cnt;
        bus.ps2_data_i = 1'b0;
        cyc(HALF);
        bus.ps2_clk_i = 1'b0;
        cyc(1);
        bus.ps2_clk_i = 1'b1;
        cyc(HALF);
        bus.ps2_data_i = 1'b1;
        cyc(HALF);
        send_frame(8'h33, 1'b0);
        check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
        check("glitch_stb",    32'(stb_cnt - s0), 32'd1);
        check("glitch_key",    32'(bus.ps2_key), 32'h233);

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        cyc(3);
        check("midrst_key",  32'(bus.ps2_key), 32'h000);
        check("midrst_byte", 32'(bus.rx_byte), 32'h00);
        check("midrst_stb",  32'(bus.rx_stb),  32'h0);
        reset_n = 1'b1;
        bus.ps2_data_i = 1'b1;
        cyc(20);
        send_frame(8'h1C, 1'b0);
        check("post_rst_byte", 32'(bus.rx_byte), 32'h1C);
        check("post_rst_key",  32'(bus.ps2_key), 32'h61C);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
